digital_clock_core: RTL and testbench

- Timekeeping stage directly downstream of the 50 MHz to 1 Hz divider. Runs in the clk_50mHz domain and consumes clk_1Hz as a data input: rising edges of clk_1Hz are detected and treated as one-second ticks.
- Maintains an HH:MM:SS BCD time of day, supports manual minute/hour setting, and drives a 4-digit multiplexed seven-segment display showing HH.MM with a 1 Hz blinking separator dot.

---
 rtl/digital_clock_pkg.sv | 38 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/digital_clock_core.sv | 119 +++++++++++
 tb/tb_digital_clock_core.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/digital_clock_pkg.sv
// Shared constants and BCD helper for the digital clock core.
// Segment patterns are active-low, gfedcba ordering.
package digital_clock_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] DIG_MIN_ONES  = 2'd0;
    localparam logic [1:0] DIG_MIN_TENS  = 2'd1;
    localparam logic [1:0] DIG_HOUR_ONES = 2'd2;
    localparam logic [1:0] DIG_HOUR_TENS = 2'd3;

    localparam logic [7:0] SEC_MAX_BCD = 8'h59;
    localparam logic [7:0] MIN_MAX_BCD = 8'h59;

    // Two-digit BCD increment that wraps to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern (gfedcba).
// Non-BCD codes show a blank digit.
module seg7_decode
    import digital_clock_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digital_clock_core.sv
// HH:MM:SS BCD timekeeping driven by 1 Hz ticks, with manual setting and
// a multiplexed 4-digit HH.MM display whose dot blinks with the seconds.
module digital_clock_core
    import digital_clock_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk_50mHz,
    input  logic       rst_n,
    input  logic       clk_1Hz,
    input  logic       run,
    input  logic       set_min,
    input  logic       set_hour,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int              SCAN_W       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [7:0]      HOUR_MAX_BCD = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));

    logic [7:0]        sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic              tick_prev_q, min_prev_q, hour_prev_q;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        dig_q, dig_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        nibble;
    logic [6:0]        seg7;
    logic              tick_ev, min_ev, hour_ev, tick_ok, sec_wrap, min_wrap, scan_wrap;

    seg7_decode u_seg7 (
        .bcd_i (nibble),
        .seg_o (seg7)
    );

    always_comb begin
        tick_ev  = clk_1Hz & ~tick_prev_q;
        min_ev   = set_min & ~min_prev_q;
        hour_ev  = set_hour & ~hour_prev_q;
        // A minute set clears seconds, so a coincident tick has nothing to land on.
        tick_ok  = tick_ev & run & ~min_ev;
        sec_wrap = (sec_q == SEC_MAX_BCD);
        min_wrap = (min_q == MIN_MAX_BCD);

        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (min_ev) begin
            sec_d = 8'h00;
            min_d = bcd_inc(min_q, MIN_MAX_BCD);
        end else if (tick_ok) begin
            sec_d = bcd_inc(sec_q, SEC_MAX_BCD);
            if (sec_wrap) begin
                min_d = bcd_inc(min_q, MIN_MAX_BCD);
            end
        end
        if (hour_ev) begin
            hour_d = bcd_inc(hour_q, HOUR_MAX_BCD);
        end else if (tick_ok && sec_wrap && min_wrap) begin
            hour_d = bcd_inc(hour_q, HOUR_MAX_BCD);
        end
    end

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        dig_d      = scan_wrap ? dig_q + 2'd1 : dig_q;

        nibble = min_q[3:0];
        case (dig_q)
            DIG_MIN_ONES:  nibble = min_q[3:0];
            DIG_MIN_TENS:  nibble = min_q[7:4];
            DIG_HOUR_ONES: nibble = hour_q[3:0];
            DIG_HOUR_TENS: nibble = hour_q[7:4];
            default:       nibble = min_q[3:0];
        endcase

        an_d  = ~(4'b0001 << dig_q);
        seg_d = {~((dig_q == DIG_HOUR_ONES) & ~sec_q[0]), seg7};
    end

    always_ff @(posedge clk_50mHz) begin
        if (!rst_n) begin
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            tick_prev_q <= 1'b1;
            min_prev_q  <= 1'b1;
            hour_prev_q <= 1'b1;
            scan_cnt_q  <= '0;
            dig_q       <= 2'd0;
            an_q        <= 4'b1110;
            seg_q       <= 8'hC0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            tick_prev_q <= clk_1Hz;
            min_prev_q  <= set_min;
            hour_prev_q <= set_hour;
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign sec_bcd  = sec_q;
    assign min_bcd  = min_q;
    assign hour_bcd = hour_q;
    assign an       = an_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_digital_clock_core.sv
// Scoreboard bench for digital_clock_core: a decimal time model predicts
// each cycle's time, and the scan outputs are checked against fixed tables.
module tb_digital_clock_core;

    localparam int HMAX = 23;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1Hz = 1'b0;
    logic       run = 1'b1;
    logic       set_min = 1'b0;
    logic       set_hour = 1'b0;
    logic [7:0] sec_bcd, min_bcd, hour_bcd, seg;
    logic [3:0] an;

    int total = 0;
    int bad = 0;
    int mh = 0, mm = 0, ms = 0;
    logic [23:0] exp_q[$];

    logic [3:0] an_exp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg_exp [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};

    always #5 clk = ~clk;

    digital_clock_core #(.SCAN_DIV(4), .HOUR_MAX(HMAX)) dut (
        .clk_50mHz (clk),
        .rst_n     (rst_n),
        .clk_1Hz   (clk_1Hz),
        .run       (run),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .an        (an),
        .seg       (seg)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [23:0] mdl_time();
        return {to_bcd(mh), to_bcd(mm), to_bcd(ms)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_check(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'hFFFF_FFFF);
        end else begin
            chk(tag, {8'h00, hour_bcd, min_bcd, sec_bcd}, {8'h00, exp_q.pop_front()});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clk_1Hz = 1'b1; set_min = 1'b1; set_hour = 1'b1;
        mh = 0; mm = 0; ms = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        exp_q.push_back(mdl_time());
        sb_check("rst_time");
        chk("rst_an", {28'h0, an}, 32'h0000_000E);
        chk("rst_seg", {24'h0, seg}, 32'h0000_00C0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back(mdl_time());
        sb_check("rst_hold");
        clk_1Hz = 1'b0; set_min = 1'b0; set_hour = 1'b0;
        @(negedge clk);
    endtask

    // Raise the selected inputs for 'hold' cycles; an event fires once at the first edge.
    task automatic pulse(input bit t, input bit m, input bit h, input int hold);
        @(negedge clk);
        clk_1Hz = t; set_min = m; set_hour = h;
        if (m) begin
            mm = (mm + 1) % 60;
            ms = 0;
        end else if (t && run) begin
            ms++;
            if (ms == 60) begin
                ms = 0;
                mm++;
                if (mm == 60) begin
                    mm = 0;
                    if (!h) mh = (mh == HMAX) ? 0 : mh + 1;
                end
            end
        end
        if (h) mh = (mh == HMAX) ? 0 : mh + 1;
        exp_q.push_back(mdl_time());
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            sb_check("time");
            if (i < hold - 1) begin
                exp_q.push_back(mdl_time());
            end else begin
                clk_1Hz = 1'b0; set_min = 1'b0; set_hour = 1'b0;
            end
        end
    endtask

    task automatic wait_an(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = an;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (prev != target && an == target) ok = 1'b1;
            prev = an;
        end
    endtask

    initial begin
        bit ok;

        do_reset();

        // 60 ticks, some with clk_1Hz held high for several cycles
        for (int i = 0; i < 60; i++) pulse(1'b1, 1'b0, 1'b0, (i % 7 == 0) ? 5 : 1);
        chk("roll_min", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0000_0100);

        // reset mid-count, then run enable
        do_reset();
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 1'b0, 1);
        run = 1'b0;
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 2);
        run = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1);
        chk("run_resume", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0000_0011);

        // minute setting from 00:58:30
        do_reset();
        for (int i = 0; i < 58; i++) pulse(1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 30; i++) pulse(1'b1, 1'b0, 1'b0, 1);
        pulse(1'b0, 1'b1, 1'b0, 10);
        chk("set_min_59", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0000_5900);
        pulse(1'b0, 1'b1, 1'b0, 1);
        chk("set_min_wrap", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0000_0000);

        // full-day rollover from 23:59:59
        for (int i = 0; i < 23; i++) pulse(1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0, 1'b0, 1);
        chk("pre_day", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0023_5959);
        pulse(1'b1, 1'b0, 1'b0, 1);
        chk("day_wrap", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0000_0000);

        // tick + set_hour collision at 05:59:59
        do_reset();
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0, 1'b0, 1);
        pulse(1'b1, 1'b0, 1'b1, 1);
        chk("tick_hour", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0006_0000);

        // tick + set_min collision at 05:10:20
        do_reset();
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0, 1'b0, 1);
        pulse(1'b1, 1'b1, 1'b0, 1);
        chk("tick_min", {8'h00, hour_bcd, min_bcd, sec_bcd}, 32'h0005_1100);

        // display scan at 12:34:00
        do_reset();
        for (int i = 0; i < 12; i++) pulse(1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 34; i++) pulse(1'b0, 1'b1, 1'b0, 1);
        wait_an(4'hE, ok);
        if (!ok) chk("scan_sync_timeout", {28'h0, an}, 32'h0000_000E);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                chk("scan_an", {28'h0, an}, {28'h0, an_exp[k]});
                chk("scan_seg", {24'h0, seg}, {24'h0, seg_exp[k]});
            end
        end
        pulse(1'b1, 1'b0, 1'b0, 1);
        wait_an(4'hB, ok);
        if (!ok) chk("dp_sync_timeout", {28'h0, an}, 32'h0000_000B);
        chk("dp_odd_seg", {24'h0, seg}, 32'h0000_00A4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
